// File: rtl/timer_share_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// timer_share_ctrl_pkg
// Shared definitions for the shared-timer sequencer:
//   state_t  - sequencer states (IDLE, RUN, DONE)
//   onehot() - one-hot decode of a requester index, MAX_REQ bits wide;
//              callers keep the low NREQ bits.
// ---------------------------------------------------------------------------
package timer_share_ctrl_pkg;

  localparam int MAX_REQ = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
    onehot = MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/timer_share_ctrl_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. The search starts at ptr and
// wraps around, so the requester at ptr has the highest priority.
// Ports:
//   req     in  NREQ  request vector
//   ptr     in  IW    highest-priority index
//   win     out NREQ  one-hot winner (0 when no request)
//   win_idx out IW    winner index (0 when no request)
//   any     out 1     at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx,
  output logic            any
);

  always_comb begin : search
    int          s;
    logic [IW-1:0] c;
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    s       = 0;
    c       = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = int'(ptr) + k;
      if (s >= NREQ) s = s - NREQ;
      c = IW'(s);
      if (!any && req[c]) begin
        any     = 1'b1;
        win_idx = c;
        win[c]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_share_ctrl.sv
// ---------------------------------------------------------------------------
// timer_share_ctrl
// Shares one N-bit up/down loadable counter among NREQ requesters. A granted
// requester gets a counting run from its start value (down: len, up: 0) to
// its end value (down: 0, up: len) and a one-cycle done pulse afterwards.
// Ports:
//   clk    in  1       clock, rising edge
//   rst_n  in  1       synchronous active-low reset
//   req    in  NREQ    request levels
//   dir    in  NREQ    direction per requester (1 = up, 0 = down)
//   len    in  NREQ*N  run length, requester i at [i*N +: N]
//   gnt    out NREQ    one-hot grant for the whole run (RUN and DONE)
//   done   out NREQ    one-hot completion pulse (DONE)
//   busy   out 1       state is not IDLE
//   count  out N       shared counter value
// All outputs decode registers only.
// ---------------------------------------------------------------------------
module timer_share_ctrl
  import timer_share_ctrl_pkg::*;
#(
  parameter int N    = 4,
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] dir,
  input  logic [NREQ*N-1:0] len,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic [N-1:0]    count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t        state, state_n;
  logic [N-1:0]  cnt, cnt_n;
  logic [IW-1:0] owner, owner_n;
  logic [IW-1:0] ptr, ptr_n;
  logic          dir_q, dir_n;
  logic [N-1:0]  end_q, end_n;

  logic [NREQ-1:0] win;
  logic [IW-1:0]   win_idx;
  logic            any;
  logic [N-1:0]    len_a [NREQ];
  logic [N-1:0]    len_w;
  logic [MAX_REQ-1:0] owner_oh;

  for (genvar i = 0; i < NREQ; i++) begin : g_len
    assign len_a[i] = len[i*N +: N];
  end

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  assign len_w = len_a[win_idx];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    owner_n = owner;
    ptr_n   = ptr;
    dir_n   = dir_q;
    end_n   = end_q;
    unique case (state)
      IDLE: begin
        if (any) begin
          owner_n = win_idx;
          dir_n   = dir[win_idx];
          end_n   = dir[win_idx] ? len_w : '0;
          cnt_n   = dir[win_idx] ? '0 : len_w;
          // Pointer moves past the owner at grant time, so an aborted run
          // still hands priority on.
          ptr_n   = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        // Abort wins over completion.
        if (!req[owner]) begin
          state_n = IDLE;
        end else if (cnt == end_q) begin
          state_n = DONE;
        end else begin
          cnt_n = dir_q ? cnt + 1'b1 : cnt - 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      owner <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      owner <= owner_n;
      ptr   <= ptr_n;
    end
  end

  // Run parameters are only meaningful in RUN/DONE, after a load.
  always_ff @(posedge clk) begin
    dir_q <= dir_n;
    end_q <= end_n;
  end

  assign owner_oh = onehot(32'(owner));
  assign gnt      = (state != IDLE) ? owner_oh[NREQ-1:0] : '0;
  assign done     = (state == DONE) ? owner_oh[NREQ-1:0] : '0;
  assign busy     = (state != IDLE);
  assign count    = cnt;

endmodule

// File: tb/tb_timer_share_ctrl.sv
module tb_timer_share_ctrl;

  localparam int N    = 4;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   dir;
  logic [NREQ*N-1:0] len;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [N-1:0]      count;

  int n_checks = 0;
  int n_fail   = 0;

  timer_share_ctrl #(.N(N), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .dir   (dir),
    .len   (len),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_gnt"},  32'(gnt),  32'h0);
    check_eq({tag, "_done"}, 32'(done), 32'h0);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  // Single requester i runs alone: grant in cycle 1, RUN for l+1 cycles,
  // DONE in cycle l+2, requester drops req on done.
  task automatic run_one(input int i, input logic d, input int l, input string tag);
    req[i]         = 1'b1;
    dir[i]         = d;
    len[i*N +: N]  = N'(l);
    tick();
    for (int c = 0; c <= l; c++) begin
      check_eq({tag, "_run_gnt"},   32'(gnt),   32'(1) << i);
      check_eq({tag, "_run_cnt"},   32'(count), d ? 32'(c) : 32'(l - c));
      check_eq({tag, "_run_done"},  32'(done),  32'h0);
      check_eq({tag, "_run_busy"},  32'(busy),  32'h1);
      if (c < l) tick();
    end
    tick();
    check_eq({tag, "_dn_done"}, 32'(done),  32'(1) << i);
    check_eq({tag, "_dn_gnt"},  32'(gnt),   32'(1) << i);
    check_eq({tag, "_dn_cnt"},  32'(count), d ? 32'(l) : 32'h0);
    req[i] = 1'b0;
    tick();
    check_idle({tag, "_idle"});
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    dir   = '0;
    len   = '0;
    tick();
    tick();
    check_idle("reset");
    check_eq("reset_cnt", 32'(count), 32'h0);
    rst_n = 1'b1;
    tick();
    check_idle("reset_hold");

    // Down run len 3 for requester 0: counts 3,2,1,0, then DONE
    run_one(0, 1'b0, 3, "down3");
    // Up run len 5 for requester 2
    run_one(2, 1'b1, 5, "up5");
    // Zero-length runs, both directions
    run_one(1, 1'b1, 0, "up0");
    run_one(3, 1'b0, 0, "down0");

    // Round robin with all four requesting, len 1 each; pointer now 0
    req = 4'b1111;
    dir = 4'b0101;
    len = {4'd1, 4'd1, 4'd1, 4'd1};
    for (int g = 0; g < 5; g++) begin
      tick();
      check_eq("rr_gnt", 32'(gnt), 32'(1) << (g % 4));
      tick();
      check_eq("rr_gnt2", 32'(gnt), 32'(1) << (g % 4));
      tick();
      check_eq("rr_done", 32'(done), 32'(1) << (g % 4));
      req[g % 4] = 1'b0;
      tick();
      check_idle("rr_idle");
      if (g < 4) req[g % 4] = 1'b1;
      else       req = '0;
    end
    // Pointer is now 1

    // Abort: requester 1 down from 6, dropped in third RUN cycle
    req = 4'b0110;
    dir = 4'b0100;
    len = {4'd0, 4'd2, 4'd6, 4'd0};
    tick();
    check_eq("ab_gnt1", 32'(gnt), 32'h2);
    check_eq("ab_cnt1", 32'(count), 32'd6);
    tick();
    check_eq("ab_cnt2", 32'(count), 32'd5);
    tick();
    check_eq("ab_cnt3", 32'(count), 32'd4);
    req[1] = 1'b0;
    tick();
    check_idle("ab_idle");
    req[1] = 1'b1;  // re-request: pointer must now favour requester 2
    tick();
    check_eq("ab_next_gnt", 32'(gnt), 32'h4);
    check_eq("ab_next_cnt", 32'(count), 32'd0);
    tick();
    check_eq("ab_next_cnt1", 32'(count), 32'd1);
    tick();
    check_eq("ab_next_cnt2", 32'(count), 32'd2);
    tick();
    check_eq("ab_next_done", 32'(done), 32'h4);
    req = '0;
    tick();
    check_idle("ab_end");
    // Pointer is now 3

    // Reset mid-run: requester 1 (pointer 3 -> 0 -> 1) down from 9
    req = 4'b0010;
    dir = 4'b0001;
    len = {4'd0, 4'd0, 4'd9, 4'd2};
    tick();
    check_eq("rs_gnt", 32'(gnt), 32'h2);
    tick();
    tick();
    check_eq("rs_cnt", 32'(count), 32'd7);
    rst_n = 1'b0;
    req   = 4'b0111;
    tick();
    check_idle("rs_idle");
    check_eq("rs_cnt0", 32'(count), 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("rs_first_gnt", 32'(gnt), 32'h1);
    check_eq("rs_first_cnt", 32'(count), 32'd0);
    // Changing len during the run must not move the end value (still 2)
    len[0 +: N] = 4'd7;
    tick();
    check_eq("lat_cnt1", 32'(count), 32'd1);
    tick();
    check_eq("lat_cnt2", 32'(count), 32'd2);
    tick();
    check_eq("lat_done", 32'(done), 32'h1);
    check_eq("lat_cnt_dn", 32'(count), 32'd2);
    req = '0;
    tick();
    check_idle("lat_idle");

    // Full-scale up run, no wrap past 15
    run_one(3, 1'b1, 15, "up15");
    check_eq("up15_hold", 32'(count), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
